booth_multiplier: RTL and testbench



---
 rtl/booth_multiplier.sv | 76 +++++++
 tb/tb_booth_multiplier.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: 16x16 unsigned -> 32-bit product.
// Operands are zero-extended to 17 bits so the signed recoding gives the unsigned result.
module booth_multiplier (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_A,
  input  logic [15:0] in_B,
  input  logic        ld,
  input  logic        ld_PP,
  output logic [31:0] product
);

  logic [16:0] m_q;
  logic [16:0] a_q;
  logic [16:0] q_q;
  logic [15:0] b_q;
  logic        qm1_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic [31:0] product_q;

  logic [16:0] a_sum;
  logic [16:0] a_next;
  logic [16:0] q_next;

  // One Booth step: add/subtract, then arithmetic shift of {A, Q, Qm1}.
  always_comb begin
    a_sum = a_q;
    case ({q_q[0], qm1_q})
      2'b01:   a_sum = a_q + m_q;
      2'b10:   a_sum = a_q - m_q;
      default: a_sum = a_q;
    endcase
    a_next = {a_sum[16], a_sum[16:1]};
    q_next = {a_sum[0], q_q[16:1]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      b_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      product_q <= '0;
    end else if (ld) begin
      m_q    <= {1'b0, in_A};
      q_q    <= {1'b0, in_B};
      b_q    <= in_B;
      a_q    <= '0;
      qm1_q  <= 1'b0;
      busy_q <= 1'b0;
    end else if (ld_PP) begin
      // Q is consumed by the shifts, so restart from the shadow copy.
      a_q    <= '0;
      q_q    <= {1'b0, b_q};
      qm1_q  <= 1'b0;
      cnt_q  <= 5'd17;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      a_q   <= a_next;
      q_q   <= q_next;
      qm1_q <= q_q[0];
      cnt_q <= cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        busy_q    <= 1'b0;
        product_q <= {a_next[14:0], q_next};
      end
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Scoreboard bench for booth_multiplier: stimulus queues expected products with the
// cycle at which they must appear; a monitor compares them on the falling edge.
module tb_booth_multiplier;

  logic        clk;
  logic        reset;
  logic [15:0] in_A;
  logic [15:0] in_B;
  logic        ld;
  logic        ld_PP;
  logic [31:0] product;

  booth_multiplier dut (
    .clk     (clk),
    .reset   (reset),
    .in_A    (in_A),
    .in_B    (in_B),
    .ld      (ld),
    .ld_PP   (ld_PP),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] val;
    int unsigned due;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_prod;

  // Monitor: product is stable between rising edges.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      n_cmp++;
      if (product !== mon_e.val) begin
        n_bad++;
        $display("FAIL %s: product=0x%08h expected 0x%08h (cycle %0d)",
                 mon_e.name, product, mon_e.val, cyc);
      end
    end
  end

  function automatic void push(input logic [31:0] v, input int unsigned due, input string nm);
    exp_t e;
    e.val  = v;
    e.due  = due;
    e.name = nm;
    sb.push_back(e);
  endfunction

  // Pulse ld_PP; product must hold until 17 edges after the sampling edge, then update.
  task automatic issue_pp(input logic [31:0] exp, input string nm);
    int unsigned k;
    @(negedge clk);
    ld    = 1'b0;
    ld_PP = 1'b1;
    k = cyc + 1;
    push(last_prod, k + 16, {nm, "_hold"});
    push(exp, k + 17, nm);
    @(negedge clk);
    ld_PP = 1'b0;
    repeat (17) @(negedge clk);
    last_prod = exp;
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b,
                     input logic [31:0] exp, input string nm);
    @(negedge clk);
    ld   = 1'b1;
    in_A = a;
    in_B = b;
    issue_pp(exp, nm);
  endtask

  initial begin
    int unsigned k1;
    int unsigned k2;
    logic [15:0] ra;
    logic [15:0] rb;

    reset = 1'b0;
    ld    = 1'b0;
    ld_PP = 1'b0;
    in_A  = '0;
    in_B  = '0;
    last_prod = '0;
    push(32'h0, 1, "reset_state");
    @(negedge clk);
    reset = 1'b1;

    run(16'd3, 16'd5, 32'h0000_000F, "mul_3x5");
    // Inputs change without ld: rerun must reuse the loaded operands.
    @(negedge clk);
    in_A = 16'hAAAA;
    in_B = 16'h5555;
    issue_pp(32'h0000_000F, "rerun_shadow_b");

    run(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "mul_max");
    run(16'h8000, 16'h0002, 32'h0001_0000, "mul_8000x2");
    run(16'h1234, 16'h0000, 32'h0000_0000, "mul_by_zero");
    run(16'h00FF, 16'h0100, 32'h0000_FF00, "mul_ff_100");

    // Reset in the middle of a run clears product and kills the run.
    run(16'd7, 16'd9, 32'd63, "mul_7x9_pre");
    @(negedge clk);
    ld   = 1'b1;
    in_A = 16'h00FF;
    in_B = 16'h0100;
    @(negedge clk);
    ld    = 1'b0;
    ld_PP = 1'b1;
    k1 = cyc + 1;
    @(negedge clk);
    ld_PP = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    push(32'h0, k1 + 5, "rst_mid_clear");
    @(negedge clk);
    reset = 1'b1;
    push(32'h0, k1 + 17, "rst_no_update");
    push(32'h0, k1 + 20, "rst_no_update_late");
    repeat (17) @(negedge clk);
    last_prod = '0;

    // No ld since reset: operands are zero.
    issue_pp(32'h0, "zero_operands_after_reset");
    run(16'h00FF, 16'h0100, 32'h0000_FF00, "rerun_after_reset");

    // Restart with a second ld_PP while busy.
    run(16'd7, 16'd9, 32'd63, "mul_7x9");
    @(negedge clk);
    ld   = 1'b1;
    in_A = 16'd100;
    in_B = 16'd200;
    @(negedge clk);
    ld    = 1'b0;
    ld_PP = 1'b1;
    k1 = cyc + 1;
    @(negedge clk);
    ld_PP = 1'b0;
    repeat (3) @(negedge clk);
    ld_PP = 1'b1;
    k2 = cyc + 1;
    push(32'd63, k1 + 17, "restart_old_done_time");
    push(32'd63, k2 + 16, "restart_hold");
    push(32'd20000, k2 + 17, "restart_result");
    @(negedge clk);
    ld_PP = 1'b0;
    repeat (17) @(negedge clk);
    last_prod = 32'd20000;

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      run(ra, rb, {16'h0, ra} * {16'h0, rb}, "random");
    end

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
